rgb2videoaxis_buf: RTL and testbench

//  Parallel RGB video (hsync/vsync/de) to AXI4-Stream video bridge with an output FIFO, so
//  m_axis_tready backpressure is honoured. Sits between the video receiver and VDMA/vision blocks.

---
 rtl/rgb2videoaxis_buf.sv | 151 +++++++++++++++
 tb/tb_rgb2videoaxis_buf.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb2videoaxis_buf.sv
// Parallel RGB (hsync/vsync/de) to AXI4-Stream video bridge with output FIFO,
// frame-aligned overflow recovery and active-resolution measurement.
module rgb2videoaxis_buf #(
    parameter int DATA_W     = 24,
    parameter int FIFO_DEPTH = 1024,
    parameter bit HS_POL     = 1'b1,
    parameter bit VS_POL     = 1'b0
) (
    input  logic                        vid_clk,
    input  logic                        rst,
    input  logic                        hsync,
    input  logic                        vsync,
    input  logic                        de,
    input  logic [DATA_W-1:0]           rgb_data,
    output logic [DATA_W-1:0]           m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tuser,
    output logic                        m_axis_tlast,
    output logic                        overflow,
    input  logic                        clr_overflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [15:0]                 resolution_width,
    output logic [15:0]                 resolution_height
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int WW = DATA_W + 2;

    localparam logic [1:0] S_WAIT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    logic              vs_q, vs_qq, hs_q, hs_qq, de_q;
    logic [DATA_W-1:0] p_data_q;
    logic [1:0]        state_q, state_d;
    logic              sof_pend_q, sof_pend_d;
    logic              overflow_q, overflow_d;
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]     level_q, level_d;
    logic              full_q;
    logic [15:0]       x_cnt_q, y_cnt_q, res_w_q, res_h_q;
    logic [WW-1:0]     mem [FIFO_DEPTH];
    logic [WW-1:0]     rd_word;

    logic vs_a, hs_a, vs_edge, hs_rise, de_fall;
    logic running, wr_req, push, drop, pop, empty;

    assign vs_a    = (vsync == VS_POL);
    assign hs_a    = (hsync == HS_POL);
    assign vs_edge = vs_q & ~vs_qq;
    assign hs_rise = hs_q & ~hs_qq;
    assign de_fall = de_q & ~de;

    // P is flushed whenever the previous cycle loaded a pixel
    assign wr_req  = de_q;
    assign running = (state_q == S_RUN);
    assign push    = running & wr_req & ~full_q;
    assign drop    = running & wr_req & full_q;
    assign empty   = (level_q == '0);
    assign pop     = ~empty & m_axis_tready;
    assign level_d = level_q + LW'(push) - LW'(pop);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT:  if (vs_edge) state_d = S_RUN;
            S_RUN:   if (drop)    state_d = S_DROP;
            S_DROP:  if (vs_edge) state_d = S_RUN;
            default: state_d = S_WAIT;
        endcase
    end

    always_comb begin
        sof_pend_d = sof_pend_q;
        if (vs_edge)   sof_pend_d = 1'b1;
        else if (push) sof_pend_d = 1'b0;
        overflow_d = overflow_q;
        if (drop)              overflow_d = 1'b1;
        else if (clr_overflow) overflow_d = 1'b0;
    end

    always_ff @(posedge vid_clk or posedge rst) begin
        if (rst) begin
            vs_q       <= 1'b0;
            vs_qq      <= 1'b0;
            hs_q       <= 1'b0;
            hs_qq      <= 1'b0;
            de_q       <= 1'b0;
            p_data_q   <= '0;
            state_q    <= S_WAIT;
            sof_pend_q <= 1'b0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
        end else begin
            vs_q       <= vs_a;
            vs_qq      <= vs_q;
            hs_q       <= hs_a;
            hs_qq      <= hs_q;
            de_q       <= de;
            if (de) p_data_q <= rgb_data;
            state_q    <= state_d;
            sof_pend_q <= sof_pend_d;
            overflow_q <= overflow_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q    <= level_d;
            full_q     <= (level_d == LW'(FIFO_DEPTH));
        end
    end

    // storage needs no reset; reads are masked while empty
    always_ff @(posedge vid_clk) begin
        if (push) mem[wr_ptr_q] <= {sof_pend_q, ~de, p_data_q};
    end

    always_ff @(posedge vid_clk or posedge rst) begin
        if (rst) begin
            x_cnt_q <= '0;
            y_cnt_q <= '0;
            res_w_q <= '0;
            res_h_q <= '0;
        end else begin
            if (hs_rise)
                x_cnt_q <= '0;
            else if (de && x_cnt_q != 16'hFFFF)
                x_cnt_q <= x_cnt_q + 16'd1;
            if (vs_edge)
                y_cnt_q <= '0;
            else if (de_fall && y_cnt_q != 16'hFFFF)
                y_cnt_q <= y_cnt_q + 16'd1;
            if (de_fall) res_w_q <= x_cnt_q;
            if (vs_edge) res_h_q <= y_cnt_q;
        end
    end

    assign rd_word           = mem[rd_ptr_q];
    assign m_axis_tvalid     = ~empty;
    assign m_axis_tdata      = empty ? '0 : rd_word[DATA_W-1:0];
    assign m_axis_tlast      = empty ? 1'b0 : rd_word[DATA_W];
    assign m_axis_tuser      = empty ? 1'b0 : rd_word[DATA_W+1];
    assign overflow          = overflow_q;
    assign fifo_level        = level_q;
    assign resolution_width  = res_w_q;
    assign resolution_height = res_h_q;

endmodule

// File: tb/tb_rgb2videoaxis_buf.sv
// Scoreboard bench for rgb2videoaxis_buf: a depth-8 and a depth-64 instance
// share the video inputs; one is selected for output checking per step.
module tb_rgb2videoaxis_buf;

    localparam int DW = 24;
    localparam int DA = 8;
    localparam int DB = 64;

    typedef logic [DW+1:0] word_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic hsync = 1'b0;
    logic vsync = 1'b1;
    logic de = 1'b0;
    logic [DW-1:0] rgb = '0;
    logic clr = 1'b0;
    logic tready_fix = 1'b0;
    logic tready_rnd = 1'b0;
    logic rand_mode = 1'b0;
    logic tready;
    logic sel = 1'b1;

    logic [DW-1:0] a_data, b_data, m_data;
    logic a_valid, a_user, a_last, a_ovf;
    logic b_valid, b_user, b_last, b_ovf;
    logic m_valid, m_user, m_last;
    logic [3:0] a_level;
    logic [6:0] b_level;
    logic [15:0] a_w, a_h, b_w, b_h;

    int n_tests = 0;
    int n_fail = 0;
    int budget = -1;
    bit sof_exp = 1'b0;
    word_t exp_q[$];
    bit stall_p = 1'b0;
    word_t prev_w = '0;

    assign tready  = rand_mode ? tready_rnd : tready_fix;
    assign m_valid = sel ? b_valid : a_valid;
    assign m_data  = sel ? b_data : a_data;
    assign m_user  = sel ? b_user : a_user;
    assign m_last  = sel ? b_last : a_last;

    rgb2videoaxis_buf #(.DATA_W(DW), .FIFO_DEPTH(DA)) dut_a (
        .vid_clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync), .de(de),
        .rgb_data(rgb), .m_axis_tdata(a_data), .m_axis_tvalid(a_valid),
        .m_axis_tready(tready), .m_axis_tuser(a_user), .m_axis_tlast(a_last),
        .overflow(a_ovf), .clr_overflow(clr), .fifo_level(a_level),
        .resolution_width(a_w), .resolution_height(a_h)
    );

    rgb2videoaxis_buf #(.DATA_W(DW), .FIFO_DEPTH(DB)) dut_b (
        .vid_clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync), .de(de),
        .rgb_data(rgb), .m_axis_tdata(b_data), .m_axis_tvalid(b_valid),
        .m_axis_tready(tready), .m_axis_tuser(b_user), .m_axis_tlast(b_last),
        .overflow(b_ovf), .clr_overflow(clr), .fifo_level(b_level),
        .resolution_width(b_w), .resolution_height(b_h)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        tready_rnd = 1'($urandom_range(0, 1));
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        word_t cur;
        word_t e;
        cur = {m_user, m_last, m_data};
        if (rst) begin
            stall_p = 1'b0;
        end else begin
            if (stall_p) begin
                chk("stall_valid", 64'(m_valid), 64'd1);
                chk("stall_word", 64'(cur), 64'(prev_w));
            end
            if (m_valid && tready) begin
                chk("beat_pending", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("beat_word", 64'(cur), 64'(e));
                end
            end
            stall_p = m_valid & ~tready;
            prev_w  = cur;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic vs_pulse();
        vsync = 1'b0;
        repeat (3) tick();
        vsync = 1'b1;
        repeat (4) tick();
        sof_exp = 1'b1;
    endtask

    task automatic send_line(input int w, input bit push_en);
        hsync = 1'b1;
        repeat (2) tick();
        hsync = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < w; i++) begin
            de  = 1'b1;
            rgb = DW'($urandom);
            if (push_en && budget != 0) begin
                exp_q.push_back({sof_exp, (i == w - 1), rgb});
                sof_exp = 1'b0;
                if (budget > 0) budget--;
            end
            tick();
        end
        de  = 1'b0;
        rgb = '0;
        repeat (4) tick();
    endtask

    task automatic send_frame(input int w, input int h, input bit push_en);
        vs_pulse();
        for (int l = 0; l < h; l++) send_line(w, push_en);
    endtask

    task automatic reset_all(input bit s);
        rst = 1'b1;
        tready_fix = 1'b0;
        rand_mode = 1'b0;
        de = 1'b0;
        hsync = 1'b0;
        vsync = 1'b1;
        clr = 1'b0;
        tick();
        sel = s;
        exp_q.delete();
        budget = -1;
        sof_exp = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic drain(input string tag);
        tready_fix = 1'b1;
        for (int k = 0; k < 3000 && exp_q.size() != 0; k++) tick();
        repeat (3) tick();
        chk(tag, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        // power-on reset
        repeat (2) tick();
        chk("rst_valid", 64'(b_valid), 64'd0);
        chk("rst_word", 64'({b_user, b_last, b_data}), 64'd0);
        chk("rst_level", 64'(b_level), 64'd0);
        chk("rst_ovf", 64'(b_ovf), 64'd0);
        chk("rst_res", 64'({b_w, b_h}), 64'd0);

        // 4x3 frame, always ready, then resolution after next VS
        reset_all(1'b1);
        tready_fix = 1'b1;
        send_frame(4, 3, 1'b1);
        vs_pulse();
        drain("t1_drain");
        chk("t1_width", 64'(b_w), 64'd4);
        chk("t1_height", 64'(b_h), 64'd3);

        // pixels before the first VS edge are discarded
        reset_all(1'b1);
        tready_fix = 1'b1;
        send_line(6, 1'b0);
        chk("t2_prevs_valid", 64'(b_valid), 64'd0);
        chk("t2_prevs_level", 64'(b_level), 64'd0);
        send_frame(4, 2, 1'b1);
        drain("t2_drain");

        // depth-8 overflow, then recovery on next frame
        reset_all(1'b0);
        budget = 8;
        send_frame(8, 2, 1'b1);
        chk("t3_ovf", 64'(a_ovf), 64'd1);
        chk("t3_level", 64'(a_level), 64'(DA));
        budget = -1;
        tready_fix = 1'b1;
        send_frame(8, 2, 1'b1);
        drain("t3_drain");
        chk("t3_ovf_sticky", 64'(a_ovf), 64'd1);

        // random backpressure over three 16x4 frames
        reset_all(1'b1);
        rand_mode = 1'b1;
        repeat (3) send_frame(16, 4, 1'b1);
        drain("t4_drain");
        rand_mode = 1'b0;
        chk("t4_ovf", 64'(b_ovf), 64'd0);
        chk("t4_width", 64'(b_w), 64'd16);

        // push on a full cycle with a simultaneous pop is dropped
        reset_all(1'b0);
        budget = 8;
        vs_pulse();
        send_line(8, 1'b1);
        chk("t5_full_level", 64'(a_level), 64'(DA));
        de  = 1'b1;
        rgb = DW'($urandom);
        tick();
        de = 1'b0;
        tready_fix = 1'b1;
        tick();
        tready_fix = 1'b0;
        chk("t5_level", 64'(a_level), 64'(DA - 1));
        chk("t5_ovf", 64'(a_ovf), 64'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("t5_clr", 64'(a_ovf), 64'd0);
        drain("t5_drain");

        // asynchronous reset mid-line
        reset_all(1'b1);
        vs_pulse();
        hsync = 1'b1;
        repeat (2) tick();
        hsync = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 5; i++) begin
            de  = 1'b1;
            rgb = DW'($urandom);
            tick();
        end
        chk("t6_pre_level", 64'(b_level), 64'd4);
        rgb = DW'($urandom);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_valid", 64'(b_valid), 64'd0);
        chk("t6_word", 64'({b_user, b_last, b_data}), 64'd0);
        chk("t6_level", 64'(b_level), 64'd0);
        chk("t6_ovf_res", 64'({b_ovf, b_w, b_h}), 64'd0);
        tick();
        de = 1'b0;
        tick();
        rst = 1'b0;
        tready_fix = 1'b1;
        tick();
        send_line(10, 1'b0);
        repeat (5) tick();
        chk("t6_novs_valid", 64'(b_valid), 64'd0);
        send_frame(4, 1, 1'b1);
        drain("t6_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
